// File: rtl/meta_rr_arbiter.sv
// Round-robin arbiter that funnels per-requester metadata words into one
// registered output slot feeding the downstream meta FIFO.
module meta_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned META_W  = 192,
  parameter int unsigned IDW     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*META_W-1:0] req_bus,
  input  logic                      en,
  input  logic                      fifo_almost_full,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [META_W-1:0]         out_bus,
  output logic [IDW-1:0]            out_src,
  output logic [31:0]               grant_cnt,
  output logic                      busy
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] last_gnt;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           found;
  logic           can_acc;
  logic           accept;

  // Ascending search with wrap, starting just after the last granted requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((32'(last_gnt) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // The slot can take a word when empty or when its current word leaves this cycle.
  assign can_acc = ~rst & en & ~fifo_almost_full & (~out_valid | out_ready);
  assign accept  = found & can_acc;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign out_valid = (state_q == FULL);
  assign busy      = out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      out_bus   <= '0;
      out_src   <= '0;
      grant_cnt <= '0;
      last_gnt  <= IDW'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        out_bus   <= req_bus[32'(winner) * META_W +: META_W];
        out_src   <= winner;
        last_gnt  <= winner;
        grant_cnt <= grant_cnt + CNT_W'(1);
      end
      case (state_q)
        EMPTY: if (accept) state_q <= FULL;
        FULL:  if (!accept && out_ready) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
